// File: rtl/uart_pkg.sv
// Shared definitions for the MMIO UART transmitter: FSM states, register
// offsets and STATUS/CTRL bit positions.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam int STS_FULL_BIT  = 0;
    localparam int STS_EMPTY_BIT = 1;
    localparam int STS_BUSY_BIT  = 2;
    localparam int STS_OVF_BIT   = 3;
    localparam int STS_CNT_LSB   = 4;
    localparam int STS_CNT_MSB   = 8;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_CLR_BIT    = 1;
    localparam int CTRL_OVFCLR_BIT = 2;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with a combinational head read; a push is accepted only
// when the count before the edge is below DEPTH, independent of a same-cycle pop.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wp_q, rp_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rp_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wp_q <= wp_q + 1'b1;
            if (do_pop)  rp_q <= rp_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i && !reset_i) mem_q[wp_q] <= wdata_i;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/CTRL window in front of a
// small FIFO feeding a start/data/stop serialiser with registered line outputs.
module mmio_uart_tx import uart_pkg::*; #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        sel_o,
    output logic        tx_o,
    output logic        busy_o
);
    localparam int CW  = $clog2(CLKS_PER_BIT);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

    logic [1:0]     off;
    logic           wr_tx, wr_ctrl, clr, pop;
    logic           f_full, f_empty;
    logic [FCW-1:0] f_cnt;
    logic [7:0]     f_head;

    uart_state_e    state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [2:0]     bidx_q, bidx_d;
    logic [7:0]     shreg_q, shreg_d;
    logic           tx_q, tx_d;
    logic           busy_q, en_q, ovf_q;
    logic           tick, unused_bits;

    assign sel_o   = (addr_i[31:4] == BASE_ADDR[31:4]);
    assign off     = addr_i[3:2];
    assign wr_tx   = we_i && sel_o && (off == REG_TXDATA);
    assign wr_ctrl = we_i && sel_o && (off == REG_CTRL);
    assign clr     = wr_ctrl && wdata_i[CTRL_CLR_BIT];
    assign unused_bits = ^{addr_i[1:0], wdata_i[31:8]};

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (clr),
        .push_i  (wr_tx),
        .pop_i   (pop),
        .wdata_i (wdata_i[7:0]),
        .rdata_o (f_head),
        .full_o  (f_full),
        .empty_o (f_empty),
        .count_o (f_cnt)
    );

    always_comb begin
        rdata_o = '0;
        if (sel_o) begin
            case (off)
                REG_STATUS: begin
                    rdata_o[STS_FULL_BIT]               = f_full;
                    rdata_o[STS_EMPTY_BIT]              = f_empty;
                    rdata_o[STS_BUSY_BIT]               = busy_q;
                    rdata_o[STS_OVF_BIT]                = ovf_q;
                    rdata_o[STS_CNT_MSB:STS_CNT_LSB]    = 5'(f_cnt);
                end
                REG_CTRL: rdata_o[CTRL_EN_BIT] = en_q;
                default:  rdata_o = '0;
            endcase
        end
    end

    assign tick = (cnt_q == LAST_CNT);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        bidx_d  = bidx_q;
        shreg_d = shreg_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (en_q && !f_empty) begin
                    pop     = 1'b1;
                    shreg_d = f_head;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (tick) begin
                    cnt_d   = '0;
                    bidx_d  = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (tick) begin
                    cnt_d = '0;
                    if (bidx_q == 3'd7) state_d = ST_STOP;
                    else                bidx_d  = bidx_q + 3'd1;
                end
            end
            default: begin
                // back-to-back frames: reload straight into START, no idle bit
                if (tick) begin
                    cnt_d = '0;
                    if (en_q && !f_empty) begin
                        pop     = 1'b1;
                        shreg_d = f_head;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_comb begin
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shreg_d[bidx_d];
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bidx_q  <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            en_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bidx_q  <= bidx_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            busy_q  <= (state_d != ST_IDLE);
            if (wr_ctrl) en_q <= wdata_i[CTRL_EN_BIT];
            if (wr_tx && f_full)                               ovf_q <= 1'b1;
            else if (wr_ctrl && wdata_i[CTRL_OVFCLR_BIT])      ovf_q <= 1'b0;
        end
    end

    assign tx_o   = tx_q;
    assign busy_o = busy_q;

endmodule
